riscv_mc_ctrl_fsm: RTL and testbench

- Next-generation multicycle RV32I main controller: sequences fetch/decode/execute/memory/writeback and drives datapath enables and mux selects.
- Adds a variable-latency memory handshake with a parametrised timeout.
- Adds the full branch set (BEQ/BNE/BLT/BGE/BLTU/BGEU) from ALU flags, plus an ALU-op class output.
- Adds sticky halt with a fault code. Sits between the instruction register decode fields and the multicycle datapath.

---
 rtl/riscv_mc_ctrl_fsm.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_riscv_mc_ctrl_fsm.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_ctrl_fsm.sv
// Multicycle RV32I main controller: sequences fetch/decode/execute/memory/writeback and
//   drives datapath enables and mux selects; halts stickily with a fault code.
// Latency: outputs are Moore-decoded from the state register. Only the FETCH completion strobes
//   follow mem_ready combinationally. Backpressure: memory requests are held until mem_ready,
//   or until the wait counter reaches MEM_TIMEOUT, which faults the core.
//
// Optional feature (macro RISCV_MC_CTRL_PERF_EN): adds the cycle_cnt and instret_cnt counters.
//
// Ports:
//   clk, rst                    clock (rising edge) and synchronous active-high reset
//   opcode, funct3, funct7      instruction register decode fields (funct7 is unused here)
//   flag_zero/lt/ltu            ALU compare flags used by branches
//   mem_ready                   memory completes the current access this cycle
//   pc_write, old_pc_write,     register enables
//   ir_write, reg_write
//   addr_src                    memory address mux select
//   mem_read, mem_write         memory requests
//   wb_src, pc_src              writeback and PC source mux selects
//   alu_op, alu_src_a/b         ALU operation class and operand mux selects
//   halted, fault               sticky halt status and its cause
//   state_o                     current state code, for debug
//   cycle_cnt, instret_cnt      performance counters (only with the optional feature)
module riscv_mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 8,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       flag_zero,
  input  logic       flag_lt,
  input  logic       flag_ltu,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       old_pc_write,
  output logic       addr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] wb_src,
  output logic       pc_src,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       halted,
  output logic [1:0] fault,
  output logic [4:0] state_o
`ifdef RISCV_MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  typedef enum logic [4:0] {
    S_FETCH     = 5'd0,
    S_DECODE    = 5'd1,
    S_EXEC_R    = 5'd2,
    S_EXEC_I    = 5'd3,
    S_EXEC_LUI  = 5'd4,
    S_EXEC_AUI  = 5'd5,
    S_MEM_ADDR  = 5'd6,
    S_MEM_LOAD  = 5'd7,
    S_MEM_STORE = 5'd8,
    S_WB_MEM    = 5'd9,
    S_WB_ALU    = 5'd10,
    S_JAL_WB    = 5'd11,
    S_JALR_WB   = 5'd12,
    S_JUMP      = 5'd13,
    S_BR_CMP    = 5'd14,
    S_BR_TAKE   = 5'd15,
    S_HALT      = 5'd31
  } state_t;

  localparam logic [TMO_W-1:0] LP_TMO = TMO_W'(MEM_TIMEOUT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMO_W-1:0] r_wait;
  logic [1:0]       r_fault;
  logic [1:0]       w_fault_nxt;
  logic             w_mem_pend;
  logic             w_tmo;
  logic             w_br_taken;
  logic             w_br_illegal;
  logic             w_unused;

  // funct7 is decoded by the ALU control, not here.
  assign w_unused = ^{funct7, (CNT_W > 0)};

  // A request is outstanding in every state that talks to memory.
  assign w_mem_pend = (r_state == S_FETCH) || (r_state == S_MEM_LOAD) ||
                      (r_state == S_MEM_STORE);

  // Timeout only fires when the limit is reached without completion; a
  // same-cycle mem_ready lets the access finish normally.
  assign w_tmo = (MEM_TIMEOUT != 0) && w_mem_pend && (r_wait == LP_TMO) && !mem_ready;

  always_comb begin
    w_br_taken   = 1'b0;
    w_br_illegal = 1'b0;
    case (funct3)
      3'b000:  w_br_taken = flag_zero;
      3'b001:  w_br_taken = !flag_zero;
      3'b100:  w_br_taken = flag_lt;
      3'b101:  w_br_taken = !flag_lt;
      3'b110:  w_br_taken = flag_ltu;
      3'b111:  w_br_taken = !flag_ltu;
      default: w_br_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_fault <= FLT_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= w_fault_nxt;
      // Leaving a memory state also clears, so every access starts from zero.
      if (!w_mem_pend || mem_ready) begin
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + TMO_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fault_nxt  = r_fault;
    pc_write     = 1'b0;
    old_pc_write = 1'b0;
    addr_src     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    wb_src       = 2'b00;
    pc_src       = 1'b0;
    alu_op       = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    reg_write    = 1'b0;
    halted       = 1'b0;
    fault        = r_fault;
    state_o      = r_state;

    case (r_state)
      S_FETCH: begin
        // ALU computes PC+4 while the instruction is read.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          pc_write     = 1'b1;
          ir_write     = 1'b1;
          old_pc_write = 1'b1;
          w_state_nxt  = S_DECODE;
        end else if (w_tmo) begin
          w_state_nxt = S_HALT;
          w_fault_nxt = FLT_TIMEOUT;
        end
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut for branches and JAL.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (opcode)
          OP_R:      w_state_nxt = S_EXEC_R;
          OP_I:      w_state_nxt = S_EXEC_I;
          OP_LOAD,
          OP_STORE:  w_state_nxt = S_MEM_ADDR;
          OP_LUI:    w_state_nxt = S_EXEC_LUI;
          OP_AUIPC:  w_state_nxt = S_EXEC_AUI;
          OP_JAL:    w_state_nxt = S_JAL_WB;
          OP_JALR:   w_state_nxt = S_JALR_WB;
          OP_BRANCH: w_state_nxt = S_BR_CMP;
          default: begin
            w_state_nxt = S_HALT;
            w_fault_nxt = FLT_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_op      = 2'b10;
        w_state_nxt = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b10;
        alu_op      = 2'b10;
        w_state_nxt = S_WB_ALU;
      end
      S_EXEC_LUI: begin
        alu_src_a   = 2'b11;
        alu_src_b   = 2'b10;
        w_state_nxt = S_WB_ALU;
      end
      S_EXEC_AUI: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        w_state_nxt = S_WB_ALU;
      end
      S_WB_ALU: begin
        wb_src      = 2'b01;
        reg_write   = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b10;
        w_state_nxt = (opcode == OP_LOAD) ? S_MEM_LOAD : S_MEM_STORE;
      end
      S_MEM_LOAD: begin
        addr_src = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          w_state_nxt = S_WB_MEM;
        end else if (w_tmo) begin
          w_state_nxt = S_HALT;
          w_fault_nxt = FLT_TIMEOUT;
        end
      end
      S_MEM_STORE: begin
        addr_src  = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          w_state_nxt = S_FETCH;
        end else if (w_tmo) begin
          w_state_nxt = S_HALT;
          w_fault_nxt = FLT_TIMEOUT;
        end
      end
      S_WB_MEM: begin
        reg_write   = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_JAL_WB: begin
        wb_src      = 2'b10;
        reg_write   = 1'b1;
        pc_write    = 1'b1;
        pc_src      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_JALR_WB: begin
        // rd gets PC+4 while rs1+imm is computed into ALUOut for JUMP.
        wb_src      = 2'b10;
        reg_write   = 1'b1;
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b10;
        w_state_nxt = S_JUMP;
      end
      S_JUMP, S_BR_TAKE: begin
        pc_write    = 1'b1;
        pc_src      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_BR_CMP: begin
        // Not-taken needs no PC update: FETCH already wrote PC+4.
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        if (w_br_illegal) begin
          w_state_nxt = S_HALT;
          w_fault_nxt = FLT_ILLEGAL;
        end else if (w_br_taken) begin
          w_state_nxt = S_BR_TAKE;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    // Reset masks every output so an abandoned access issues no strobe.
    if (rst) begin
      pc_write     = 1'b0;
      old_pc_write = 1'b0;
      addr_src     = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      wb_src       = 2'b00;
      pc_src       = 1'b0;
      alu_op       = 2'b00;
      alu_src_a    = 2'b00;
      alu_src_b    = 2'b00;
      reg_write    = 1'b0;
      halted       = 1'b0;
      fault        = FLT_NONE;
      state_o      = 5'd0;
    end
  end

`ifdef RISCV_MC_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else if (r_state != S_HALT) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      // An instruction retires when control returns to FETCH.
      if ((r_state != S_FETCH) && (w_state_nxt == S_FETCH)) begin
        r_instret_cnt <= r_instret_cnt + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt   = rst ? '0 : r_cycle_cnt;
  assign instret_cnt = rst ? '0 : r_instret_cnt;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl_fsm.sv
// Bench for riscv_mc_ctrl_fsm: instruction-level model expands each instruction into its
//   expected cycle trace; a single loop drives inputs per cycle and compares all outputs.
// Operand values drive both the ALU flags and the model's branch decision.
module tb_riscv_mc_ctrl_fsm;

  localparam int MEM_TO = 4;

  localparam logic [4:0] FETCH = 5'd0, DECODE = 5'd1, EXEC_R = 5'd2, EXEC_I = 5'd3;
  localparam logic [4:0] EXEC_LUI = 5'd4, EXEC_AUI = 5'd5, MEM_ADDR = 5'd6, MEM_LOAD = 5'd7;
  localparam logic [4:0] MEM_STORE = 5'd8, WB_MEM = 5'd9, WB_ALU = 5'd10, JAL_WB = 5'd11;
  localparam logic [4:0] JALR_WB = 5'd12, JUMP = 5'd13, BR_CMP = 5'd14, BR_TAKE = 5'd15;
  localparam logic [4:0] HALT = 5'd31;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_BR = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk, rst, flag_zero, flag_lt, flag_ltu, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic pc_write, old_pc_write, addr_src, mem_read, mem_write, ir_write, pc_src, reg_write, halted;
  logic [1:0] wb_src, alu_op, alu_src_a, alu_src_b, fault;
  logic [4:0] state_o;
`ifdef RISCV_MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
  logic [31:0] m_cyc, m_inst;
  logic [4:0]  prev_st;
  logic        prev_rst;
`endif

  riscv_mc_ctrl_fsm #(.MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .flag_zero(flag_zero), .flag_lt(flag_lt), .flag_ltu(flag_ltu), .mem_ready(mem_ready),
    .pc_write(pc_write), .old_pc_write(old_pc_write), .addr_src(addr_src),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .wb_src(wb_src),
    .pc_src(pc_src), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .halted(halted), .fault(fault), .state_o(state_o)
`ifdef RISCV_MC_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       rst, rdy;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       z, lt, ltu;
    logic [4:0] st;
    logic       pcw, opcw, irw, asrc, mrd, mwr;
    logic [1:0] wb;
    logic       psrc;
    logic [1:0] aop, sa, sb;
    logic       rw, hlt;
    logic [1:0] flt;
  } step_t;

  step_t q[$];
  logic [6:0] cur_opc;
  logic [2:0] cur_f3;
  logic cur_z, cur_lt, cur_ltu;
  logic [1:0] cur_flt;
  int n_chk, n_fail, step_no;
  int obs_n, obs_pcw, obs_rw, obs_aop10, obs_mrd_a, obs_halt, obs_first_halt;
  logic [4:0] obs_last_st;
  logic [1:0] obs_last_flt;

  // Expected control word for one cycle spent in a given step.
  function automatic step_t mk(input logic [4:0] st, input logic rdy);
    step_t e;
    e = '0;
    e.rdy = rdy; e.opc = cur_opc; e.f3 = cur_f3;
    e.z = cur_z; e.lt = cur_lt; e.ltu = cur_ltu; e.st = st;
    case (st)
      FETCH:     begin e.mrd = 1; e.sb = 2'b01; e.pcw = rdy; e.opcw = rdy; e.irw = rdy; end
      DECODE:    begin e.sa = 2'b01; e.sb = 2'b10; end
      EXEC_R:    begin e.sa = 2'b10; e.aop = 2'b10; end
      EXEC_I:    begin e.sa = 2'b10; e.sb = 2'b10; e.aop = 2'b10; end
      EXEC_LUI:  begin e.sa = 2'b11; e.sb = 2'b10; end
      EXEC_AUI:  begin e.sa = 2'b01; e.sb = 2'b10; end
      MEM_ADDR:  begin e.sa = 2'b10; e.sb = 2'b10; end
      MEM_LOAD:  begin e.asrc = 1; e.mrd = 1; end
      MEM_STORE: begin e.asrc = 1; e.mwr = 1; end
      WB_MEM:    begin e.rw = 1; end
      WB_ALU:    begin e.rw = 1; e.wb = 2'b01; end
      JAL_WB:    begin e.rw = 1; e.wb = 2'b10; e.pcw = 1; e.psrc = 1; end
      JALR_WB:   begin e.rw = 1; e.wb = 2'b10; e.sa = 2'b10; e.sb = 2'b10; end
      JUMP, BR_TAKE: begin e.pcw = 1; e.psrc = 1; end
      BR_CMP:    begin e.sa = 2'b10; e.aop = 2'b01; end
      HALT:      begin e.hlt = 1; e.flt = cur_flt; end
      default:   ;
    endcase
    return e;
  endfunction

  task automatic push(input logic [4:0] st, input logic rdy);
    q.push_back(mk(st, rdy));
  endtask

  task automatic halt_for(input logic [1:0] f, input int n);
    cur_flt = f;
    for (int i = 0; i < n; i++) push(HALT, i[0]);
  endtask

  task automatic reset_for(input int n);
    step_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.rst = 1; e.rdy = 1; e.opc = cur_opc;
      q.push_back(e);
    end
    cur_flt = 2'b00;
  endtask

  // An access may wait at most MEM_TO cycles; ready on any of those completes it.
  task automatic mem_access(input logic [4:0] st, input int lat, output bit ok);
    if (lat > MEM_TO) begin
      for (int i = 0; i <= MEM_TO; i++) push(st, 1'b0);
      ok = 0;
    end else begin
      for (int i = 0; i < lat; i++) push(st, 1'b0);
      push(st, 1'b1);
      ok = 1;
    end
  endtask

  task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input int lf, input int lm);
    bit ok;
    bit taken;
    cur_opc = opc; cur_f3 = f3;
    cur_z = (a == b); cur_lt = ($signed(a) < $signed(b)); cur_ltu = (a < b);
    mem_access(FETCH, lf, ok);
    if (!ok) halt_for(2'b10, 3);
    else begin
      push(DECODE, 1'b0);
      case (opc)
        OP_R:    begin push(EXEC_R, 0);   push(WB_ALU, 0); end
        OP_I:    begin push(EXEC_I, 0);   push(WB_ALU, 0); end
        OP_LUI:  begin push(EXEC_LUI, 0); push(WB_ALU, 0); end
        OP_AUI:  begin push(EXEC_AUI, 0); push(WB_ALU, 0); end
        OP_LD: begin
          push(MEM_ADDR, 0);
          mem_access(MEM_LOAD, lm, ok);
          if (ok) push(WB_MEM, 0); else halt_for(2'b10, 3);
        end
        OP_ST: begin
          push(MEM_ADDR, 0);
          mem_access(MEM_STORE, lm, ok);
          if (!ok) halt_for(2'b10, 3);
        end
        OP_JAL:  push(JAL_WB, 0);
        OP_JALR: begin push(JALR_WB, 0); push(JUMP, 0); end
        OP_BR: begin
          push(BR_CMP, 0);
          ok = 1; taken = 0;
          case (f3)
            3'd0: taken = (a == b);
            3'd1: taken = (a != b);
            3'd4: taken = ($signed(a) < $signed(b));
            3'd5: taken = ($signed(a) >= $signed(b));
            3'd6: taken = (a < b);
            3'd7: taken = (a >= b);
            default: ok = 0;
          endcase
          if (!ok) halt_for(2'b01, 3);
          else if (taken) push(BR_TAKE, 0);
        end
        default: halt_for(2'b01, 3);
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, step_no, act, exp);
    end
  endtask

  task automatic play();
    step_t e;
    obs_n = 0; obs_pcw = 0; obs_rw = 0; obs_aop10 = 0; obs_mrd_a = 0; obs_halt = 0;
    obs_first_halt = -1;
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      @(negedge clk);
      rst = e.rst; mem_ready = e.rdy; opcode = e.opc; funct3 = e.f3;
      funct7 = 7'($urandom);
      flag_zero = e.z; flag_lt = e.lt; flag_ltu = e.ltu;
`ifdef RISCV_MC_CTRL_PERF_EN
      if (!e.rst && !prev_rst && e.st == FETCH && prev_st != FETCH) m_inst++;
`endif
      #2;
      step_no++;
      chk("state_o", state_o, e.st);
      chk("pc_write", pc_write, e.pcw);
      chk("old_pc_write", old_pc_write, e.opcw);
      chk("ir_write", ir_write, e.irw);
      chk("addr_src", addr_src, e.asrc);
      chk("mem_read", mem_read, e.mrd);
      chk("mem_write", mem_write, e.mwr);
      chk("wb_src", wb_src, e.wb);
      chk("pc_src", pc_src, e.psrc);
      chk("alu_op", alu_op, e.aop);
      chk("alu_src_a", alu_src_a, e.sa);
      chk("alu_src_b", alu_src_b, e.sb);
      chk("reg_write", reg_write, e.rw);
      chk("halted", halted, e.hlt);
      chk("fault", fault, e.flt);
`ifdef RISCV_MC_CTRL_PERF_EN
      chk("cycle_cnt", cycle_cnt, e.rst ? 32'd0 : m_cyc);
      chk("instret_cnt", instret_cnt, e.rst ? 32'd0 : m_inst);
      if (e.rst) begin m_cyc = 0; m_inst = 0; end
      else if (e.st != HALT) m_cyc++;
      prev_st = e.st; prev_rst = e.rst;
`endif
      obs_n++;
      obs_pcw += int'(pc_write);
      obs_rw += int'(reg_write);
      obs_aop10 += int'(alu_op == 2'b10);
      obs_mrd_a += int'(mem_read && addr_src);
      obs_halt += int'(halted);
      if (halted && obs_first_halt < 0) obs_first_halt = i;
      obs_last_st = state_o; obs_last_flt = fault;
    end
    q.delete();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; step_no = 0;
    rst = 1; mem_ready = 0; opcode = '0; funct3 = '0; funct7 = '0;
    flag_zero = 0; flag_lt = 0; flag_ltu = 0;
    cur_opc = '0; cur_f3 = '0; cur_z = 0; cur_lt = 0; cur_ltu = 0; cur_flt = '0;
`ifdef RISCV_MC_CTRL_PERF_EN
    m_cyc = 0; m_inst = 0; prev_st = 5'd0; prev_rst = 1;
`endif

    reset_for(2); play();

    // ADD, zero-latency memory: four cycles, one reg_write, one alu_op=10 cycle.
    instr(OP_R, 3'd0, 32'd3, 32'd4, 0, 0); play();
    chk("add_cycles", obs_n, 4);
    chk("add_reg_write_cnt", obs_rw, 1);
    chk("add_aluop10_cnt", obs_aop10, 1);

    instr(OP_I, 3'd0, 32'd1, 32'd1, 2, 0);
    instr(OP_LUI, 3'd0, 32'd0, 32'd0, 0, 0);
    instr(OP_AUI, 3'd0, 32'd0, 32'd0, 1, 0);
    play();

    // LW with 3 wait cycles: address request held 4 cycles, one PC write.
    instr(OP_LD, 3'd2, 32'd0, 32'd0, 0, 3); play();
    chk("lw_memread_addr1_cycles", obs_mrd_a, 4);
    chk("lw_pc_write_pulses", obs_pcw, 1);

    instr(OP_ST, 3'd2, 32'd0, 32'd0, 1, 0);
    instr(OP_LD, 3'd2, 32'd0, 32'd0, MEM_TO, MEM_TO);   // ready exactly at the limit
    instr(OP_ST, 3'd2, 32'd0, 32'd0, 0, MEM_TO);
    play();

    instr(OP_BR, 3'd6, 32'd1, 32'd2, 0, 0); play();
    chk("bltu_taken_pc_writes", obs_pcw, 2);
    instr(OP_BR, 3'd6, 32'd5, 32'd2, 0, 0); play();
    chk("bltu_not_taken_pc_writes", obs_pcw, 1);
    chk("bltu_not_taken_cycles", obs_n, 3);

    for (int f = 0; f < 8; f++) begin
      if (f != 2 && f != 3) begin
        instr(OP_BR, 3'(f), 32'hFFFF_FFFF, 32'd1, 0, 0);
        instr(OP_BR, 3'(f), 32'd7, 32'd7, 0, 0);
        instr(OP_BR, 3'(f), 32'd2, 32'h8000_0000, 0, 0);
      end
    end
    play();

    instr(OP_JAL, 3'd0, 32'd0, 32'd0, 0, 0);
    instr(OP_JALR, 3'd0, 32'd0, 32'd0, 0, 0);
    play();

    // Fetch never completes: HALT entered after MEM_TO+1 cycles and held.
    instr(OP_R, 3'd0, 32'd0, 32'd0, 10, 0);
    halt_for(2'b10, 97);
    play();
    chk("tmo_first_halt_cycle", obs_first_halt, 5);
    chk("tmo_halt_cycles", obs_halt, 100);
    chk("tmo_fault", obs_last_flt, 2'b10);
    reset_for(1); push(FETCH, 1'b0); play();
    chk("post_reset_state", obs_last_st, 5'd0);
    chk("post_reset_fault", obs_last_flt, 2'b00);

    instr(OP_R, 3'd0, 32'd0, 32'd0, 0, 0);
    instr(OP_BAD, 3'd0, 32'd0, 32'd0, 0, 0);
    play();
    chk("illegal_state", obs_last_st, HALT);
    chk("illegal_fault", obs_last_flt, 2'b01);
    reset_for(2);
    instr(OP_BR, 3'd2, 32'd0, 32'd0, 0, 0);
    reset_for(1);
    instr(OP_BR, 3'd3, 32'd0, 32'd0, 0, 0);
    reset_for(1);
    instr(OP_LD, 3'd2, 32'd0, 32'd0, 0, 9);
    reset_for(1);
    instr(OP_ST, 3'd2, 32'd0, 32'd0, 0, 6);
    reset_for(1);
    play();

    // Reset mid-EXEC_R, then three back-to-back ALU instructions.
    instr(OP_R, 3'd0, 32'd0, 32'd0, 0, 0);
    push(FETCH, 1'b1); push(DECODE, 1'b0); push(EXEC_R, 1'b0);
    reset_for(1);
    for (int k = 0; k < 3; k++) instr(OP_R, 3'd0, 32'd0, 32'd0, 0, 0);
    play();
`ifdef RISCV_MC_CTRL_PERF_EN
    @(posedge clk); #1;
    chk("perf_cycle_cnt", cycle_cnt, 32'd12);
    chk("perf_instret_cnt", instret_cnt, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
